midi_decoder: RTL and testbench

Receive-side counterpart to the MIDI note encoder. Parses a raw MIDI byte stream, one byte per `byte_valid` strobe from the UART receiver, and emits decoded note events. Each event carries note-on/off, note (0-11), octave (0-3), channel and velocity, ready for the ADPCM voice allocator. Non-note traffic is parsed for length and discarded.

---
 rtl/midi_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_midi_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/midi_decoder.sv
// MIDI byte-stream parser producing note on/off events with a 2-stage output pipeline.
// Ports: clk, reset (sync active-low), midi_byte/byte_valid in; note_on, note, octave,
// channel, velocity, output_valid out. Macro MIDI_DECODER_RUNNING_STATUS_EN enables
// running status; without it every completed message returns the parser to IDLE.
module midi_decoder #(
   parameter logic [6:0]  MIDI_NOTE_BASE = 7'h00,
   parameter logic [15:0] CHANNEL_MASK   = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] midi_byte,
   input  logic       byte_valid,
   output logic       note_on,
   output logic [3:0] note,
   output logic [1:0] octave,
   output logic [3:0] channel,
   output logic [6:0] velocity,
   output logic       output_valid
);

`ifdef MIDI_DECODER_RUNNING_STATUS_EN
   localparam logic RS_EN = 1'b1;
`else
   localparam logic RS_EN = 1'b0;
`endif

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] NOTE_KEY = 3'd1;
   localparam logic [2:0] NOTE_VEL = 3'd2;
   localparam logic [2:0] SKIP     = 3'd3;
   localparam logic [2:0] SYSEX    = 3'd4;

   logic [2:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       rs_valid_q, rs_valid_d;
   logic       st_on_q, st_on_d;
   logic       st_one_q, st_one_d;
   logic [3:0] st_ch_q, st_ch_d;
   logic [6:0] key_q, key_d;

   logic       s1_valid_q, s1_valid_d;
   logic       s1_on_q, s1_on_d;
   logic [6:0] s1_key_q, s1_key_d;
   logic [6:0] s1_vel_q, s1_vel_d;
   logic [3:0] s1_ch_q, s1_ch_d;

   logic       out_valid_q, out_valid_d;
   logic       out_on_q, out_on_d;
   logic [3:0] out_note_q, out_note_d;
   logic [1:0] out_oct_q, out_oct_d;
   logic [3:0] out_ch_q, out_ch_d;
   logic [6:0] out_vel_q, out_vel_d;

   logic [7:0] k;
   logic [7:0] rem;
   logic [1:0] oct;
   logic       keep;

   // Parser and stage 1
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rs_valid_d = rs_valid_q;
      st_on_d    = st_on_q;
      st_one_d   = st_one_q;
      st_ch_d    = st_ch_q;
      key_d      = key_q;
      s1_valid_d = 1'b0;
      s1_on_d    = s1_on_q;
      s1_key_d   = s1_key_q;
      s1_vel_d   = s1_vel_q;
      s1_ch_d    = s1_ch_q;
      if (byte_valid) begin
         if (midi_byte[7]) begin
            // 0xF8-0xFF are realtime and leave the parser untouched
            if (midi_byte[7:3] != 5'b11111) begin
               st_on_d  = midi_byte[4];
               st_ch_d  = midi_byte[3:0];
               st_one_d = 1'b0;
               unique case (midi_byte[7:4])
                  4'h8, 4'h9: begin
                     state_d    = NOTE_KEY;
                     rs_valid_d = 1'b1;
                  end
                  4'hA, 4'hB, 4'hE: begin
                     state_d    = SKIP;
                     cnt_d      = 2'd2;
                     rs_valid_d = 1'b1;
                  end
                  4'hC, 4'hD: begin
                     state_d    = SKIP;
                     cnt_d      = 2'd1;
                     st_one_d   = 1'b1;
                     rs_valid_d = 1'b1;
                  end
                  default: begin
                     rs_valid_d = 1'b0;
                     unique case (midi_byte[3:0])
                        4'h0: state_d = SYSEX;
                        4'h1, 4'h3: begin
                           state_d = SKIP;
                           cnt_d   = 2'd1;
                        end
                        4'h2: begin
                           state_d = SKIP;
                           cnt_d   = 2'd2;
                        end
                        default: state_d = IDLE;
                     endcase
                  end
               endcase
            end
         end else begin
            unique case (state_q)
               NOTE_KEY: begin
                  key_d   = midi_byte[6:0];
                  state_d = NOTE_VEL;
               end
               NOTE_VEL: begin
                  s1_valid_d = 1'b1;
                  s1_on_d    = st_on_q && (midi_byte[6:0] != 7'd0);
                  s1_key_d   = key_q;
                  s1_vel_d   = midi_byte[6:0];
                  s1_ch_d    = st_ch_q;
                  state_d    = RS_EN ? NOTE_KEY : IDLE;
               end
               SKIP: begin
                  if (cnt_q == 2'd1) begin
                     // system common messages never re-arm
                     if (RS_EN && rs_valid_q) begin
                        state_d = SKIP;
                        cnt_d   = st_one_q ? 2'd1 : 2'd2;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q - 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Stage 2: range check, channel filter, octave/note split
   always_comb begin
      k    = {1'b0, s1_key_q} - {1'b0, MIDI_NOTE_BASE};
      keep = s1_valid_q && (s1_key_q >= MIDI_NOTE_BASE)
             && (k < 8'd48) && CHANNEL_MASK[s1_ch_q];
      if (k < 8'd12) begin
         oct = 2'd0;
         rem = k;
      end else if (k < 8'd24) begin
         oct = 2'd1;
         rem = k - 8'd12;
      end else if (k < 8'd36) begin
         oct = 2'd2;
         rem = k - 8'd24;
      end else begin
         oct = 2'd3;
         rem = k - 8'd36;
      end
      out_valid_d = keep;
      out_on_d    = out_on_q;
      out_note_d  = out_note_q;
      out_oct_d   = out_oct_q;
      out_ch_d    = out_ch_q;
      out_vel_d   = out_vel_q;
      if (keep) begin
         out_on_d   = s1_on_q;
         out_note_d = rem[3:0];
         out_oct_d  = oct;
         out_ch_d   = s1_ch_q;
         out_vel_d  = s1_vel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         rs_valid_q  <= 1'b0;
         st_on_q     <= 1'b0;
         st_one_q    <= 1'b0;
         st_ch_q     <= 4'd0;
         key_q       <= 7'd0;
         s1_valid_q  <= 1'b0;
         s1_on_q     <= 1'b0;
         s1_key_q    <= 7'd0;
         s1_vel_q    <= 7'd0;
         s1_ch_q     <= 4'd0;
         out_valid_q <= 1'b0;
         out_on_q    <= 1'b0;
         out_note_q  <= 4'd0;
         out_oct_q   <= 2'd0;
         out_ch_q    <= 4'd0;
         out_vel_q   <= 7'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rs_valid_q  <= rs_valid_d;
         st_on_q     <= st_on_d;
         st_one_q    <= st_one_d;
         st_ch_q     <= st_ch_d;
         key_q       <= key_d;
         s1_valid_q  <= s1_valid_d;
         s1_on_q     <= s1_on_d;
         s1_key_q    <= s1_key_d;
         s1_vel_q    <= s1_vel_d;
         s1_ch_q     <= s1_ch_d;
         out_valid_q <= out_valid_d;
         out_on_q    <= out_on_d;
         out_note_q  <= out_note_d;
         out_oct_q   <= out_oct_d;
         out_ch_q    <= out_ch_d;
         out_vel_q   <= out_vel_d;
      end
   end

   assign output_valid = out_valid_q;
   assign note_on      = out_on_q;
   assign note         = out_note_q;
   assign octave       = out_oct_q;
   assign channel      = out_ch_q;
   assign velocity     = out_vel_q;

endmodule

// File: tb/tb_midi_decoder.sv
// Scoreboard bench for midi_decoder: two instances (all channels / channel 0 only)
// share one byte stream; a negedge monitor pops expected events and checks timing.
module tb_midi_decoder;

   typedef struct {
      logic       on;
      logic [3:0] note;
      logic [1:0] oct;
      logic [3:0] ch;
      logic [6:0] vel;
      time        due;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] midi_byte = 8'h00;
   logic       byte_valid = 1'b0;

   logic       a_on, b_on, a_vld, b_vld;
   logic [3:0] a_note, b_note, a_ch, b_ch;
   logic [1:0] a_oct, b_oct;
   logic [6:0] a_vel, b_vel;

   ev_t qa[$];
   ev_t qb[$];
   int  total = 0;
   int  bad = 0;

   always #5 clk = ~clk;

   midi_decoder u_a (
      .clk(clk), .reset(reset), .midi_byte(midi_byte),
      .byte_valid(byte_valid), .note_on(a_on), .note(a_note),
      .octave(a_oct), .channel(a_ch), .velocity(a_vel),
      .output_valid(a_vld)
   );

   midi_decoder #(.CHANNEL_MASK(16'h0001)) u_b (
      .clk(clk), .reset(reset), .midi_byte(midi_byte),
      .byte_valid(byte_valid), .note_on(b_on), .note(b_note),
      .octave(b_oct), .channel(b_ch), .velocity(b_vel),
      .output_valid(b_vld)
   );

   // Monitor: compare each pulse against the head of its queue
   always @(negedge clk) begin
      ev_t e;
      if (reset && a_vld) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL a_unexpected got on=%0d ch=%0d oct=%0d note=%0d vel=%0h want none",
                     a_on, a_ch, a_oct, a_note, a_vel);
         end else begin
            e = qa.pop_front();
            if (a_on !== e.on || a_note !== e.note || a_oct !== e.oct ||
                a_ch !== e.ch || a_vel !== e.vel || $time != e.due) begin
               bad++;
               $display("FAIL a_event got on=%0d ch=%0d oct=%0d note=%0d vel=%0h t=%0t want on=%0d ch=%0d oct=%0d note=%0d vel=%0h t=%0t",
                        a_on, a_ch, a_oct, a_note, a_vel, $time,
                        e.on, e.ch, e.oct, e.note, e.vel, e.due);
            end
         end
      end
      if (reset && b_vld) begin
         total++;
         if (qb.size() == 0) begin
            bad++;
            $display("FAIL b_unexpected got on=%0d ch=%0d oct=%0d note=%0d vel=%0h want none",
                     b_on, b_ch, b_oct, b_note, b_vel);
         end else begin
            e = qb.pop_front();
            if (b_on !== e.on || b_note !== e.note || b_oct !== e.oct ||
                b_ch !== e.ch || b_vel !== e.vel || $time != e.due) begin
               bad++;
               $display("FAIL b_event got on=%0d ch=%0d oct=%0d note=%0d vel=%0h t=%0t want on=%0d ch=%0d oct=%0d note=%0d vel=%0h t=%0t",
                        b_on, b_ch, b_oct, b_note, b_vel, $time,
                        e.on, e.ch, e.oct, e.note, e.vel, e.due);
            end
         end
      end
   end

   // Called at the negedge where the velocity byte is driven
   task automatic expect_ev(input logic on, input logic [3:0] nt,
                            input logic [1:0] oc, input logic [3:0] ch,
                            input logic [6:0] vel);
      ev_t e;
      e.on = on; e.note = nt; e.oct = oc; e.ch = ch; e.vel = vel;
      e.due = $time + 20;
      qa.push_back(e);
      if (ch == 4'd0) qb.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      midi_byte  = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (5) @(negedge clk);
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain_%s pending a=%0d b=%0d want 0", name, qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   task automatic check_zero(input string name);
      total++;
      if ({a_on, a_note, a_oct, a_ch, a_vel, a_vld} !== 19'd0 ||
          {b_on, b_note, b_oct, b_ch, b_vel, b_vld} !== 19'd0) begin
         bad++;
         $display("FAIL zero_%s got a=%0h b=%0h want 0", name,
                  {a_on, a_note, a_oct, a_ch, a_vel, a_vld},
                  {b_on, b_note, b_oct, b_ch, b_vel, b_vld});
      end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_zero("por");
      reset = 1'b1;
      @(negedge clk);

      // basic note on: key 25 -> octave 2 note 1
      send(8'h92); send(8'h19);
      expect_ev(1'b1, 4'd1, 2'd2, 4'd2, 7'h40); send(8'h40);
      drain("basic");

      // velocity zero, then key 48 out of range
      send(8'h90); send(8'h05);
      expect_ev(1'b0, 4'd5, 2'd0, 4'd0, 7'h00); send(8'h00);
      send(8'h80); send(8'h30); send(8'h10);
      drain("range");

      // top of range: key 47 -> octave 3 note 11; note off with velocity
      send(8'h80); send(8'h2F);
      expect_ev(1'b0, 4'd11, 2'd3, 4'd0, 7'h01); send(8'h01);
      drain("top");

      // running status
      send(8'h91); send(8'h0C);
      expect_ev(1'b1, 4'd0, 2'd1, 4'd1, 7'h40); send(8'h40);
      send(8'h0C);
`ifdef MIDI_DECODER_RUNNING_STATUS_EN
      expect_ev(1'b0, 4'd0, 2'd1, 4'd1, 7'h00);
`endif
      send(8'h00);
      drain("running");

      // realtime bytes interleaved, then skipped messages
      send(8'h90); send(8'hF8); send(8'h05); send(8'hFE);
      expect_ev(1'b1, 4'd5, 2'd0, 4'd0, 7'h7F); send(8'h7F);
      send(8'hC3); send(8'h10);
      send(8'hB0); send(8'h07); send(8'h64);
      drain("skip");

      // sysex, then aborted message replaced by new status
      send(8'hF0); send(8'h12); send(8'h34); send(8'hF7);
      send(8'h40); send(8'h40);
      send(8'h90); send(8'h05);
      send(8'h93); send(8'h0D);
      expect_ev(1'b1, 4'd1, 2'd1, 4'd3, 7'h20); send(8'h20);
      drain("sysex");

      // back-to-back notes, no idle cycles
      send(8'h95); send(8'h00);
      expect_ev(1'b1, 4'd0, 2'd0, 4'd5, 7'h11); send(8'h11);
      send(8'h90); send(8'h17);
      expect_ev(1'b1, 4'd11, 2'd1, 4'd0, 7'h22); send(8'h22);
      drain("b2b");

      // reset mid-message
      send(8'h90); send(8'h05);
      reset = 1'b0;
      @(negedge clk);
      check_zero("midreset");
      reset = 1'b1;
      send(8'h40);
      drain("reset");

      // channel filter on instance b
      send(8'h91); send(8'h05);
      expect_ev(1'b1, 4'd5, 2'd0, 4'd1, 7'h40); send(8'h40);
      send(8'h90); send(8'h05);
      expect_ev(1'b1, 4'd5, 2'd0, 4'd0, 7'h40); send(8'h40);
      drain("mask");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
